// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory-port arbiter.
// Handshake: a requester holds req until its one-cycle valid; memory completes with ready.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIfBusy = 2'd1,
      StDmBusy = 2'd2,
      StDone   = 2'd3
   } state_e;

   typedef enum logic {
      GntIf = 1'b0,
      GntDm = 1'b1
   } gnt_e;

   localparam int unsigned WordOffW = 2;

   function automatic logic misaligned(input logic [WordOffW-1:0] lo);
      return lo != '0;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side requests and memory-side handshake of the shared memory port.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_err;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              dm_err;
   logic              stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_valid, if_err, dm_rdata, dm_valid, dm_err, stall,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_valid, if_err, dm_rdata, dm_valid, dm_err, stall,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter that flags the last allowed cycle of a memory access.
module mem_arb_watchdog #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic busy,
   output logic timeout
);
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned Last = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   logic [CntW-1:0] cnt_q, cnt_d;

   // Idle cycles hold the count at zero, so every access starts counting from 0.
   always_comb begin
      cnt_d = busy ? cnt_q + CntW'(1) : '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = (TIMEOUT != 0) && busy && (cnt_q == CntW'(Last));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and load/store.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input logic               clock,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   state_e            state_q, state_d;
   gnt_e              gnt;
   logic              if_elig, dm_elig, busy, timeout;
   logic              last_was_dm_q, last_was_dm_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
   logic              if_err_q, if_err_d, dm_err_q, dm_err_d;

   assign busy = (state_q == StIfBusy) || (state_q == StDmBusy);

   mem_arb_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .busy   (busy),
      .timeout(timeout)
   );

   assign if_elig = bus.if_req & ~if_valid_q;
   assign dm_elig = bus.dm_req & ~dm_valid_q;
   // Data side wins ties unless it won the previous grant, so fetch cannot starve.
   assign gnt = (dm_elig && !(if_elig && last_was_dm_q)) ? GntDm : GntIf;

   always_comb begin
      state_d       = state_q;
      last_was_dm_d = last_was_dm_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_rdata_d    = if_rdata_q;
      dm_rdata_d    = dm_rdata_q;
      if_valid_d    = 1'b0;
      dm_valid_d    = 1'b0;
      if_err_d      = 1'b0;
      dm_err_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (if_elig || dm_elig) begin
               last_was_dm_d = (gnt == GntDm);
               if (gnt == GntDm && misaligned(bus.dm_addr[WordOffW-1:0])) begin
                  state_d    = StDone;
                  dm_valid_d = 1'b1;
                  dm_err_d   = 1'b1;
               end else if (gnt == GntDm) begin
                  state_d     = StDmBusy;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.dm_we;
                  mem_addr_d  = {bus.dm_addr[ADDR_W-1:WordOffW], {WordOffW{1'b0}}};
                  mem_wdata_d = bus.dm_wdata;
               end else begin
                  state_d    = StIfBusy;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {bus.if_addr[ADDR_W-1:WordOffW], {WordOffW{1'b0}}};
               end
            end
         end
         StIfBusy, StDmBusy: begin
            if (bus.mem_ready || timeout) begin
               state_d   = StDone;
               mem_req_d = 1'b0;
               if (state_q == StIfBusy) begin
                  if_valid_d = 1'b1;
                  if_err_d   = ~bus.mem_ready;
                  if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
               end else begin
                  dm_valid_d = 1'b1;
                  dm_err_d   = ~bus.mem_ready;
                  if (!bus.mem_ready) begin
                     dm_rdata_d = '0;
                  end else if (!mem_we_q) begin
                     dm_rdata_d = bus.mem_rdata;
                  end
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         last_was_dm_q <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         dm_rdata_q    <= '0;
         if_valid_q    <= 1'b0;
         dm_valid_q    <= 1'b0;
         if_err_q      <= 1'b0;
         dm_err_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_was_dm_q <= last_was_dm_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_rdata_q    <= if_rdata_d;
         dm_rdata_q    <= dm_rdata_d;
         if_valid_q    <= if_valid_d;
         dm_valid_q    <= dm_valid_d;
         if_err_q      <= if_err_d;
         dm_err_q      <= dm_err_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.dm_valid  = dm_valid_q;
   assign bus.if_err    = if_err_q;
   assign bus.dm_err    = dm_err_q;
   assign bus.stall     = (bus.if_req & ~if_valid_q) | (bus.dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: memory model, grant and completion queues.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 16;
   localparam logic [31:0] BadData = 32'hBAD0_BAD0;

   typedef struct packed {logic is_dm; logic err; logic [31:0] rdata;} exp_t;
   typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} gnt_t;
   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} dreq_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];
   gnt_t        gnt_q[$];
   logic [31:0] if_todo[$];
   dreq_t       dm_todo[$];
   int          mem_wait;
   logic        mem_dead;
   logic [31:0] last_dm;
   int          mcnt;
   logic        prev_req = 1'b0;
   int          run_len = 0;
   int          last_run = 0;
   exp_t        mon_e;
   gnt_t        mon_g;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h10) return 32'h0010_0093;
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   task automatic exp_fetch(input logic [31:0] a);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      gnt_q.push_back('{addr: wa, we: 1'b0, wdata: 32'h0});
      exp_q.push_back('{is_dm: 1'b0, err: 1'b0, rdata: mem_word(wa)});
   endtask

   task automatic exp_load(input logic [31:0] a);
      gnt_q.push_back('{addr: a, we: 1'b0, wdata: 32'h0});
      last_dm = mem_word(a);
      exp_q.push_back('{is_dm: 1'b1, err: 1'b0, rdata: last_dm});
   endtask

   // Memory: ready mem_wait cycles after mem_req rises, garbage data otherwise.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = BadData;
      mcnt = 0;
      forever begin
         @(negedge clock);
         if (reset && bus.mem_req && !mem_dead) begin
            bus.mem_ready = (mcnt == mem_wait);
            bus.mem_rdata = (mcnt == mem_wait) ? mem_word(bus.mem_addr) : BadData;
            mcnt++;
         end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = BadData;
            mcnt = 0;
         end
      end
   end

   // Monitor: pops grant and completion expectations as the DUT produces them.
   always @(negedge clock) begin
      if (reset) begin
         if (bus.if_valid || bus.dm_valid) begin
            check("dual_valid", 32'(bus.if_valid & bus.dm_valid), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'({bus.if_valid, bus.dm_valid}), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("valid_port", 32'(bus.dm_valid), 32'(mon_e.is_dm));
               if (mon_e.is_dm) begin
                  check("dm_err", 32'(bus.dm_err), 32'(mon_e.err));
                  check("dm_rdata", bus.dm_rdata, mon_e.rdata);
               end else begin
                  check("if_err", 32'(bus.if_err), 32'(mon_e.err));
                  check("if_rdata", bus.if_rdata, mon_e.rdata);
               end
            end
         end
         if (bus.mem_req && !prev_req) begin
            if (gnt_q.size() == 0) begin
               check("unexpected_mem_req", 32'(bus.mem_req), 32'd0);
            end else begin
               mon_g = gnt_q.pop_front();
               check("mem_addr", bus.mem_addr, mon_g.addr);
               check("mem_we", 32'(bus.mem_we), 32'(mon_g.we));
               if (mon_g.we) check("mem_wdata", bus.mem_wdata, mon_g.wdata);
            end
         end
         if (bus.mem_req) run_len = prev_req ? run_len + 1 : 1;
         else if (prev_req) last_run = run_len;
      end
      prev_req = bus.mem_req;
   end

   // Requesters: hold req until valid, then present the next queued request or drop.
   task automatic serve(input int budget);
      int    n;
      dreq_t d;
      n = 0;
      if (if_todo.size() != 0) begin
         bus.if_addr = if_todo.pop_front();
         bus.if_req  = 1'b1;
      end
      if (dm_todo.size() != 0) begin
         d = dm_todo.pop_front();
         {bus.dm_we, bus.dm_addr, bus.dm_wdata} = {d.we, d.addr, d.wdata};
         bus.dm_req = 1'b1;
      end
      while ((bus.if_req || bus.dm_req) && n < budget) begin
         @(negedge clock);
         n++;
         check("stall", 32'(bus.stall),
               32'((bus.if_req && !bus.if_valid) || (bus.dm_req && !bus.dm_valid)));
         if (bus.if_valid) begin
            if (if_todo.size() != 0) bus.if_addr = if_todo.pop_front();
            else bus.if_req = 1'b0;
         end
         if (bus.dm_valid) begin
            if (dm_todo.size() != 0) begin
               d = dm_todo.pop_front();
               {bus.dm_we, bus.dm_addr, bus.dm_wdata} = {d.we, d.addr, d.wdata};
            end else begin
               bus.dm_req = 1'b0;
            end
         end
      end
      check("serve_done", 32'({bus.if_req, bus.dm_req}), 32'd0);
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      @(negedge clock);
      check("stall_idle", 32'(bus.stall), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int lat;
      bus.if_req = 1'b0;  bus.if_addr = '0;
      bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
      mem_wait = 0;
      mem_dead = 1'b0;
      last_dm  = '0;
      repeat (3) @(negedge clock);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check("rst_dm_valid", 32'(bus.dm_valid), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_dm_rdata", bus.dm_rdata, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Fetch only, memory ready two cycles after mem_req.
      mem_wait = 2;
      exp_fetch(32'h10);
      bus.if_addr = 32'h10;
      bus.if_req  = 1'b1;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!bus.if_valid && lat < 40);
      check("fetch_latency", 32'(lat), 32'd4);
      bus.if_req = 1'b0;
      @(negedge clock);
      check("fetch_pulse_width", 32'(bus.if_valid), 32'd0);
      check("fetch_stall_after", 32'(bus.stall), 32'd0);
      check("fetch_rdata_held", bus.if_rdata, 32'h0010_0093);

      // Simultaneous requests, zero-wait memory: data first.
      mem_wait = 0;
      exp_load(32'h100);
      exp_fetch(32'h40);
      if_todo.push_back(32'h40);
      dm_todo.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
      serve(60);

      // Back-to-back loads against a held fetch alternate grants.
      exp_load(32'h104);
      exp_fetch(32'h44);
      exp_load(32'h108);
      exp_fetch(32'h48);
      if_todo.push_back(32'h44);
      if_todo.push_back(32'h48);
      dm_todo.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
      dm_todo.push_back('{we: 1'b0, addr: 32'h108, wdata: 32'h0});
      serve(80);

      // Misaligned load: error, no memory access, counts as a data grant.
      exp_q.push_back('{is_dm: 1'b1, err: 1'b1, rdata: last_dm});
      dm_todo.push_back('{we: 1'b0, addr: 32'h203, wdata: 32'h0});
      serve(20);

      // Tie right after a data grant goes to fetch; fetch low address bits ignored.
      exp_fetch(32'h83);
      exp_load(32'h300);
      if_todo.push_back(32'h83);
      dm_todo.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
      serve(60);

      // Store leaves load data untouched.
      mem_wait = 1;
      gnt_q.push_back('{addr: 32'h204, we: 1'b1, wdata: 32'hDEAD_BEEF});
      exp_q.push_back('{is_dm: 1'b1, err: 1'b0, rdata: last_dm});
      dm_todo.push_back('{we: 1'b1, addr: 32'h204, wdata: 32'hDEAD_BEEF});
      serve(30);

      // Watchdog: memory never answers.
      mem_dead = 1'b1;
      gnt_q.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0});
      exp_q.push_back('{is_dm: 1'b1, err: 1'b1, rdata: 32'h0});
      last_dm = 32'h0;
      dm_todo.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
      serve(60);
      check("timeout_req_cycles", 32'(last_run), 32'(TIMEOUT));

      // Reset while a data access is outstanding.
      gnt_q.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0});
      {bus.dm_we, bus.dm_addr, bus.dm_wdata} = {1'b0, 32'h500, 32'h0};
      bus.dm_req = 1'b1;
      for (int i = 0; i < 10 && !bus.mem_req; i++) @(negedge clock);
      check("busy_mem_req", 32'(bus.mem_req), 32'd1);
      #2 reset = 1'b0;
      #1 check("async_mem_req_drop", 32'(bus.mem_req), 32'd0);
      bus.dm_req = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_no_dm_valid", 32'(bus.dm_valid), 32'd0);
      check("rst_if_rdata", bus.if_rdata, 32'd0);
      mem_dead = 1'b0;
      mem_wait = 1;
      reset = 1'b1;
      @(negedge clock);

      // Fresh traffic after reset: grant history is cleared, so data wins the tie.
      exp_load(32'h604);
      exp_fetch(32'h600);
      if_todo.push_back(32'h600);
      dm_todo.push_back('{we: 1'b0, addr: 32'h604, wdata: 32'h0});
      serve(60);

      repeat (3) @(negedge clock);
      check("sb_leftover", 32'(exp_q.size() + gnt_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
